key_event: RTL and testbench
============================

Name: key_event

Overview:
- Sits directly downstream of the key debouncer; consumes its clean, active-low key level (idle = 1).
- Classifies each press into single-cycle event pulses for the control logic: press, release, short press and long press.
- Optionally generates auto-repeat pulses while a long press is held.
- Runs on sysclk; all outputs are registered.

Parameters:
- CLK_CYC, 10, sysclk period in ns. Documentation only; used to derive the TICK_DIV default.
- TICK_DIV, 1_000_000/CLK_CYC, sysclk cycles per 1 ms tick. Legal range ≥ 2; overridden to small values in simulation.
- LONG_MS, 1000, hold time in ms that qualifies a long press. Legal range 1..65535.
- REPEAT_MS, 200, auto-repeat period in ms. Legal range 1..65535; used only with the optional feature.

Ports:
- sysclk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- key_in  input  1  debounced key level; 0 = pressed, 1 = released
- key_held  output  1  registered pressed status; 1 while the press is being tracked
- press_pulse  output  1  one-cycle pulse on each press
- release_pulse  output  1  one-cycle pulse on each release
- short_pulse  output  1  one-cycle pulse when a key is released before LONG_MS
- long_pulse  output  1  one-cycle pulse when the hold reaches LONG_MS
- repeat_pulse  output  1  one-cycle auto-repeat pulse; constant 0 when the feature is compiled out

Behaviour:
- Reset is asynchronous and active-low: one clock, sysclk, and rst_n clears the state asynchronously.
- Reset values:
  - key_r = 1.
  - state = IDLE.
  - Prescaler (32 bit), ms_cnt (16 bit) and rep_cnt (16 bit) = 0.
  - All outputs = 0.
- Edge detection:
  - key_r <= key_in on every clock.
  - fall = key_r & ~key_in; rise = ~key_r & key_in.
  - Each pulse output is registered, so it is high for exactly the one cycle following the clock edge that sampled its event. Latency from key_in change to pulse is 1 clock.
- Ms tick:
  - Prescaler counts 0..TICK_DIV-1; tick = 1 when prescaler == TICK_DIV-1.
  - Prescaler and ms_cnt clear on fall, so timing is aligned to the press.
  - Prescaler runs only in PRESSED and LONG_HELD; it is held at 0 in IDLE.
- FSM, IDLE:
  - On fall: press_pulse, key_held <= 1, go to PRESSED.
  - rise in IDLE (e.g. key held through reset and then released) is ignored; no pulses.
- FSM, PRESSED:
  - ms_cnt increments on each tick.
  - When tick occurs and ms_cnt == LONG_MS-1: long_pulse, go to LONG_HELD, rep_cnt <= 0.
  - On rise: release_pulse and short_pulse in the same cycle, key_held <= 0, go to IDLE.
  - Rise and the long-qualifying tick in the same cycle: release wins. Outputs are short_pulse + release_pulse with no long_pulse.
- FSM, LONG_HELD:
  - ms_cnt saturates; it does not wrap.
  - On rise: release_pulse only, key_held <= 0, go to IDLE.
- At most one press_pulse per press. Press and release pulses alternate strictly.
- Reset asserted mid-press: everything returns to reset values with no pulses. After deassertion, if key_in is still 0, no press is reported until a release followed by a new fall.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In LONG_HELD, rep_cnt increments on each tick.
  - When tick occurs and rep_cnt == REPEAT_MS-1: repeat_pulse, rep_cnt <= 0.
  - First repeat comes REPEAT_MS after long_pulse.
  - rise in the same cycle as a repeat tick: release only, no repeat_pulse.
- Not defined: rep_cnt is absent and repeat_pulse is tied to 0.

Decomposition:
- Shared package key_pkg holds:
  - State encoding enum: IDLE=2'd0, PRESSED=2'd1, LONG_HELD=2'd2.
  - MS_CNT_W = 16.
  - PRESC_W = 32.
- One natural sub-module: ms_tick_gen (prescaler with synchronous clear and enable, emitting the tick).
- FSM and counters stay in key_event.

Test Plan:
All scenarios use TICK_DIV=4, LONG_MS=3, REPEAT_MS=2.
- Reset behaviour: hold rst_n=0 with key_in toggling → all outputs stay 0. Release reset with key_in=1 → outputs stay 0 and no pulses appear.
- Short press: drive key_in 1→0, hold 8 cycles, then →1.
  - press_pulse high exactly 1 cycle, 1 clock after the fall.
  - release_pulse and short_pulse high together, 1 clock after the rise.
  - long_pulse never asserts.
- Long press: hold key_in=0 for 20 cycles.
  - long_pulse once, 12 cycles after press_pulse.
  - On release: release_pulse only, no short_pulse.
- Boundary: release timed so rise coincides with the long-qualifying tick → short_pulse + release_pulse, no long_pulse.
- Repeat (KEY_REPEAT_EN defined): hold 40 cycles.
  - repeat_pulse every 8 cycles after long_pulse.
  - Rebuild without the macro → repeat_pulse stays 0.
- Reset mid-press: assert rst_n=0 during LONG_HELD with key_in=0, then deassert → no pulses. Subsequent rise → no release_pulse.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and widths for the key event classifier.
package key_pkg;

  localparam int unsigned MS_CNT_W = 16;
  localparam int unsigned PRESC_W  = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } key_state_e;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts sysclk cycles while enabled and flags the last one.
module ms_tick_gen
  import key_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100_000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc;

  assign tick_c = en & (presc == PRESC_LAST);

  // Held at zero while disabled so every press starts from a fresh ms boundary.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (clr || !en || tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/key_event.sv
// Turns a debounced active-low key level into press/release/short/long event pulses.
// Define KEY_REPEAT_EN to add auto-repeat pulses while a long press is held.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned CLK_CYC   = 10,
  parameter int unsigned TICK_DIV  = 1_000_000 / CLK_CYC,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(LONG_MS - 1);

  key_state_e          state, state_d;
  logic [MS_CNT_W-1:0] ms_cnt, ms_cnt_d;
  logic                key_r;
  logic                armed;
  logic                fall_c, rise_c, tick_c;
  logic                held_d, press_d, release_d, short_d, long_d;

  // A key still down when reset lifts must be seen released before a new press counts.
  assign fall_c = armed & key_r & ~key_in;
  assign rise_c = ~key_r & key_in;

  ms_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .clr   (fall_c),
    .en    (state != IDLE),
    .tick_c(tick_c)
  );

`ifdef KEY_REPEAT_EN
  localparam logic [MS_CNT_W-1:0] REP_LAST = MS_CNT_W'(REPEAT_MS - 1);

  logic [MS_CNT_W-1:0] rep_cnt, rep_cnt_d;
  logic                repeat_d;
`else
  logic unused_rep_c;
  assign unused_rep_c = ^32'(REPEAT_MS);
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state;
    ms_cnt_d  = ms_cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d = rep_cnt;
    repeat_d  = 1'b0;
`endif
    case (state)
      IDLE: begin
        ms_cnt_d = '0;
        if (fall_c) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        // Release beats a coinciding long-qualifying tick.
        if (rise_c) begin
          release_d = 1'b1;
          short_d   = 1'b1;
          state_d   = IDLE;
        end else if (tick_c) begin
          ms_cnt_d = ms_cnt + MS_CNT_W'(1);
          if (ms_cnt == LONG_LAST) begin
            long_d  = 1'b1;
            state_d = LONG_HELD;
`ifdef KEY_REPEAT_EN
            rep_cnt_d = '0;
`endif
          end
        end
      end
      LONG_HELD: begin
        if (rise_c) begin
          release_d = 1'b1;
          state_d   = IDLE;
        end else if (tick_c) begin
          if (ms_cnt != '1) begin
            ms_cnt_d = ms_cnt + MS_CNT_W'(1);
          end
`ifdef KEY_REPEAT_EN
          if (rep_cnt == REP_LAST) begin
            repeat_d  = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt + MS_CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    held_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ms_cnt        <= '0;
      key_r         <= 1'b1;
      armed         <= 1'b0;
      key_held      <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_d;
      ms_cnt        <= ms_cnt_d;
      key_r         <= key_in;
      armed         <= armed | key_in;
      key_held      <= held_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      short_pulse   <= short_d;
      long_pulse    <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt      <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      rep_cnt      <= rep_cnt_d;
      repeat_pulse <= repeat_d;
    end
  end
`else
  assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event with TICK_DIV=4, LONG_MS=3, REPEAT_MS=2.
module tb_key_event;

  logic sysclk = 1'b0;
  logic rst_n;
  logic key_in;
  logic key_held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Vector order: {key_held, press, release, short, long, repeat}
  localparam logic [5:0] V_PRESS  = 6'b110000;
  localparam logic [5:0] V_LONG   = 6'b100010;
  localparam logic [5:0] V_REP    = 6'b100001;
  localparam logic [5:0] V_REL_SH = 6'b001100;
  localparam logic [5:0] V_REL    = 6'b001000;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t exp_q[$];

  key_event #(
    .CLK_CYC  (10),
    .TICK_DIV (4),
    .LONG_MS  (3),
    .REPEAT_MS(2)
  ) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .key_held     (key_held),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 sysclk = ~sysclk;

  always @(posedge sysclk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {key_held, press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse};
  endfunction

  // Monitor: every cycle with any pulse must match the next scoreboard entry.
  always @(negedge sysclk) begin
    logic [5:0] act;
    exp_t       e;
    act = outs();
    if (|act[4:0]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d got %b, required no pulse", cyc, act);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v != act) begin
          errors++;
          $display("FAIL pulse_match: got %b at cycle %0d, required %b at cycle %0d",
                   act, cyc, e.v, e.cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (outs() !== 6'b0) begin
      errors++;
      $display("FAIL %s: got %b, required 000000", name, outs());
    end
  endtask

  task automatic push(input int c, input logic [5:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Fall sampled at edge c+1; ticks every 4 cycles; long at c+13; repeats every 8 after.
  task automatic run_press(input int hold);
    int c;
    int rel;
    c   = cyc;
    rel = c + hold + 1;
    key_in = 1'b0;
    push(c + 1, V_PRESS);
    if (c + 13 < rel) push(c + 13, V_LONG);
`ifdef KEY_REPEAT_EN
    for (int e = c + 21; e < rel; e += 8) push(e, V_REP);
`endif
    push(rel, (c + 13 < rel) ? V_REL : V_REL_SH);
    step(hold);
    key_in = 1'b1;
    step(6);
  endtask

  initial begin
    int c;
    rst_n  = 1'b0;
    key_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      key_in = ~key_in;
      check_quiet("reset_hold");
    end
    key_in = 1'b1;
    step(1);
    rst_n = 1'b1;
    step(5);
    check_quiet("after_reset");

    run_press(8);
    run_press(20);
    run_press(12);
    run_press(13);
    run_press(40);
    run_press(1);

    // Reset during LONG_HELD with the key still down.
    c = cyc;
    key_in = 1'b0;
    push(c + 1, V_PRESS);
    push(c + 13, V_LONG);
    step(16);
    rst_n = 1'b0;
    #1;
    check_quiet("reset_mid_press");
    step(3);
    rst_n = 1'b1;
    step(8);
    check_quiet("held_after_reset");
    key_in = 1'b1;
    step(6);
    check_quiet("release_after_reset");

    run_press(9);

    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
